// File: rtl/dmem_block_responder_pkg.sv
// Shared constants, state encoding and helpers for the D-cache backing-memory responder.
// Optional access counters are enabled with DMEM_ACCESS_CNT_EN.
package dmem_block_responder_pkg;

    localparam int DBLOCK_SIZE_BITS = 64;
    localparam int DTAG_SIZE        = 2;
    localparam int DSET_INDEX_SIZE  = 2;
    localparam int DMEM_LATENCY     = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } rsp_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_block_responder_array.sv
// Block storage: 2^ADDR_W x BLOCK_BITS, one synchronous read/write port, contents not reset.
module dmem_block_array #(
    parameter int ADDR_W     = 4,
    parameter int BLOCK_BITS = 64
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [BLOCK_BITS-1:0] wdata_i,
    output logic [BLOCK_BITS-1:0] rdata_o
);

    logic [BLOCK_BITS-1:0] mem_q [2**ADDR_W];
    logic [BLOCK_BITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_block_responder.sv
// Block-granular refill/writeback responder with fixed latency and post-reset zero-fill.
// Define DMEM_ACCESS_CNT_EN to add saturating rd_count/wr_count outputs.
module dmem_block_responder
    import dmem_block_responder_pkg::*;
#(
    parameter int BLOCK_BITS = DBLOCK_SIZE_BITS,
    parameter int ADDR_W     = DTAG_SIZE + DSET_INDEX_SIZE,
    parameter int LATENCY    = DMEM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [BLOCK_BITS-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic                  resp_write,
    output logic [BLOCK_BITS-1:0] resp_rdata,
    input  logic                  resp_ready
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    rsp_state_e            state_q;
    logic [ADDR_W-1:0]     ptr_q;
    logic [7:0]            cnt_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  resp_write_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wr_q;
    logic [BLOCK_BITS-1:0] wdata_q;

    logic                  resp_go;
    logic                  arr_we;
    logic                  arr_re;
    logic [ADDR_W-1:0]     arr_addr;
    logic [BLOCK_BITS-1:0] arr_wdata;
    logic [BLOCK_BITS-1:0] arr_rdata;

    assign resp_go = (state_q == ST_WAIT) && (cnt_q == 8'd0);

    // The array access lands on the WAIT->RESP edge so read data is registered with resp_valid.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = addr_q;
        arr_wdata = wdata_q;
        if (state_q == ST_INIT) begin
            arr_we    = 1'b1;
            arr_addr  = ptr_q;
            arr_wdata = '0;
        end else if (resp_go) begin
            arr_we = wr_q;
            arr_re = ~wr_q;
        end
    end

    dmem_block_array #(
        .ADDR_W     (ADDR_W),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_WAIT;
                        req_ready_q <= 1'b0;
                        cnt_q       <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_write_q <= wr_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && req_valid) begin
            addr_q  <= req_addr;
            wr_q    <= req_write;
            wdata_q <= req_wdata;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_write = resp_write_q;
    assign resp_rdata = (resp_valid_q && !resp_write_q) ? arr_rdata : '0;

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == ST_RESP && resp_ready) begin
            if (resp_write_q) begin
                wr_cnt_q <= sat_inc16(wr_cnt_q);
            end else begin
                rd_cnt_q <= sat_inc16(rd_cnt_q);
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
